// File: rtl/div_pkg.sv
// Shared definitions for the iterative restoring divider: FSM encoding,
// default operand width and the divide-by-zero quotient value.
package div_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int DIV_WIDTH = 64;

  localparam logic [DIV_WIDTH-1:0] DZ_QUOTIENT = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor and keep the difference only when it did not go negative.
module div_step #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           unused_msb;

  // The partial remainder is always below the divisor, so its MSB is zero.
  assign unused_msb = rem_in[WIDTH];

  assign shifted = {rem_in[WIDTH-1:0], bit_in};
  assign trial   = shifted - {1'b0, divisor};
  assign q_bit   = ~trial[WIDTH];
  assign rem_out = q_bit ? trial : shifted;

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider: one quotient bit per cycle with
// valid/ready handshakes on the operand and result sides.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic             q_zero
);

  logic [1:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH:0]   rem_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] dvsr_reg;
  logic [WIDTH-1:0] quotient_reg;
  logic [WIDTH-1:0] remainder_reg;
  logic             div_zero_reg;
  logic             q_zero_reg;
  logic             out_valid_reg, out_valid_next;

  logic [WIDTH:0]   step_rem;
  logic             step_q;
  logic [WIDTH-1:0] quo_shift;
  logic             accept;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_reg),
    .bit_in  (quo_reg[WIDTH-1]),
    .divisor (dvsr_reg),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  assign quo_shift = {quo_reg[WIDTH-2:0], step_q};
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      out_valid_reg <= out_valid_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = (divisor == '0) ? DONE : BUSY;
      BUSY:    if (cnt_reg == '0) state_next = DONE;
      DONE:    if (out_valid_reg && out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // out_valid is registered, so it rises one cycle after DONE is entered and
  // falls right after the handshake edge.
  always_comb begin
    in_ready       = 1'b0;
    out_valid_next = 1'b0;
    case (state_reg)
      IDLE:    in_ready = 1'b1;
      DONE:    out_valid_next = !(out_valid_reg && out_ready);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg       <= '0;
      rem_reg       <= '0;
      quo_reg       <= '0;
      dvsr_reg      <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      div_zero_reg  <= 1'b0;
      q_zero_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            rem_reg  <= '0;
            quo_reg  <= dividend;
            dvsr_reg <= divisor;
            if (divisor == '0) begin
              quotient_reg  <= DZ_QUOTIENT[WIDTH-1:0];
              remainder_reg <= dividend;
              div_zero_reg  <= 1'b1;
              q_zero_reg    <= 1'b0;
            end else begin
              cnt_reg <= CNT_W'(WIDTH - 1);
            end
          end
        end
        BUSY: begin
          rem_reg <= step_rem;
          quo_reg <= quo_shift;
          if (cnt_reg == '0) begin
            quotient_reg  <= quo_shift;
            remainder_reg <= step_rem[WIDTH-1:0];
            div_zero_reg  <= 1'b0;
            q_zero_reg    <= (quo_shift == '0);
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = out_valid_reg;
  assign quotient  = quotient_reg;
  assign remainder = remainder_reg;
  assign div_zero  = div_zero_reg;
  assign q_zero    = q_zero_reg;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: expected results are queued when operands
// are driven and compared when the divider presents its result.
module tb_seq_divider;

  localparam int W = 64;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;
  logic         q_zero;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  seq_divider #(.WIDTH(W), .CNT_W(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero),
    .q_zero    (q_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("send_in_ready", W'(in_ready), W'(1));
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    if (b == '0) begin
      e.q  = '1;
      e.r  = a;
      e.dz = 1'b1;
    end else begin
      e.q  = a / b;
      e.r  = a % b;
      e.dz = 1'b0;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input int hold, input bit rdy_early);
    exp_t e;
    int   edges;
    bit   rdy_seen;
    out_ready = rdy_early;
    send(a, b);
    edges    = 1;
    rdy_seen = 1'b0;
    if (in_ready) rdy_seen = 1'b1;
    while (!out_valid && edges < 200) begin
      @(posedge clk);
      #1;
      edges++;
      if (in_ready) rdy_seen = 1'b1;
    end
    // edges counts posedges from the accept edge (exclusive) to out_valid high
    edges = edges - 1;
    check("latency", W'(edges), (b == '0) ? W'(1) : W'(65));
    check("in_ready_busy", W'(rdy_seen), W'(0));
    e = sb.pop_front();
    check("quotient", quotient, e.q);
    check("remainder", remainder, e.r);
    check("div_zero", W'(div_zero), W'(e.dz));
    check("q_zero", W'(q_zero), W'(e.q == '0));
    $display("op %0d / %0d -> q=%0d r=%0d dz=%0b qz=%0b lat=%0d",
             a, b, quotient, remainder, div_zero, q_zero, edges);
    if (!rdy_early) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        in_valid = (i == hold / 2);
        dividend = W'(3);
        divisor  = W'(1);
        @(posedge clk);
        #1;
        check("hold_out_valid", W'(out_valid), W'(1));
        check("hold_in_ready", W'(in_ready), W'(0));
        check("hold_quotient", quotient, e.q);
        check("hold_remainder", remainder, e.r);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check("drop_out_valid", W'(out_valid), W'(0));
    check("idle_in_ready", W'(in_ready), W'(1));
    check("keep_quotient", quotient, e.q);
    out_ready = 1'b0;
  endtask

  initial begin
    exp_t dropped;
    logic [W-1:0] ra, rb;

    #2;
    check("rst_in_ready", W'(in_ready), W'(1));
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_quotient", quotient, W'(0));
    check("rst_remainder", remainder, W'(0));
    check("rst_div_zero", W'(div_zero), W'(0));
    check("rst_q_zero", W'(q_zero), W'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_op(W'(100), W'(7), 0, 1'b1);
    do_op('1, W'(1), 0, 1'b1);
    do_op('1, '1, 0, 1'b1);
    do_op(W'(5), W'(9), 0, 1'b1);
    do_op(W'(7), W'(7), 0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      ra = {$urandom, $urandom};
      rb = (k[0]) ? W'($urandom_range(1, 1000)) : {$urandom, $urandom} >> k;
      if (rb == '0) rb = W'(3);
      do_op(ra, rb, 0, 1'b1);
    end
    do_op(W'(1000), W'(33), 10, 1'b0);
    do_op(W'(42), W'(0), 3, 1'b0);

    // Abort mid-operation: outputs still hold the divide-by-zero result here.
    out_ready = 1'b1;
    send(W'(123456), W'(100));
    repeat (30) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    dropped = sb.pop_front();
    check("abort_quotient", quotient, W'(0));
    check("abort_remainder", remainder, W'(0));
    check("abort_div_zero", W'(div_zero), W'(0));
    check("abort_out_valid", W'(out_valid), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_in_ready", W'(in_ready), W'(1));
    $display("op %0d / %0d aborted by reset", W'(123456), W'(100));
    do_op(W'(123456), W'(100), 0, 1'b1);
    check("fresh_quotient", quotient, W'(1234));
    check("fresh_remainder", remainder, W'(56));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
